alu_share_ctrl: RTL

- Sequencer and arbiter placing the combinational 32-bit ALU behind a request/ack interface.
- Two requesters share the ALU, e.g. the calculator control unit and the test/debug port.
- Block grants round-robin, drives the ALU operand/opcode inputs from registers, waits a programmable settle time, captures the result, and acknowledges the granted requester.

---
 rtl/alu_share_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin request/ack sequencer sharing one combinational ALU
//
// Purpose:
//   Two requesters share a single combinational ALU. The block arbitrates
//   round-robin, registers the winner's operands/opcode onto the ALU inputs,
//   holds them for SETTLE_CYCLES cycles, captures the ALU result and pulses
//   the winner's ack for one cycle.
//
// Optional feature (macro ALU_OPCHK_EN):
//   When defined, a granted opcode outside 0x01..0x09 bypasses the ALU: the
//   block goes straight to the response with result_out=0 and err_out=1.
//   When undefined, every opcode is executed and err_out is always 0.
//
// Ports:
//   CLK, RST                       clock, asynchronous active-low reset
//   req0/op1_0/op2_0/oprn_0, ack0  requester 0 request, operands, completion pulse
//   req1/op1_1/op2_1/oprn_1, ack1  requester 1 request, operands, completion pulse
//   result_out, err_out            captured result / opcode error, valid with ack
//   busy                           high whenever the sequencer is not idle
//   alu_op1/alu_op2/alu_oprn       registered ALU inputs
//   alu_result                     combinational ALU output

module alu_share_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPRN_WIDTH    = 6,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] op1_0,
  input  logic [DATA_WIDTH-1:0] op2_0,
  input  logic [OPRN_WIDTH-1:0] oprn_0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] op1_1,
  input  logic [DATA_WIDTH-1:0] op2_1,
  input  logic [OPRN_WIDTH-1:0] oprn_1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  err_out,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [OPRN_WIDTH-1:0] alu_oprn,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter loads SETTLE_CYCLES-1 so EXEC lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t                  state_q, state_d;
  logic                    last_q, last_d;   // index of the last completed grant
  logic                    gnt_q, gnt_d;     // index of the grant in flight
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   op1_q, op1_d;
  logic [DATA_WIDTH-1:0]   op2_q, op2_d;
  logic [OPRN_WIDTH-1:0]   oprn_q, oprn_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic                    err_q, err_d;

  // Arbitration: a lone request wins; on a tie the requester that did not
  // win last time is chosen.
  logic                    any_req;
  logic                    sel;
  logic [DATA_WIDTH-1:0]   sel_op1;
  logic [DATA_WIDTH-1:0]   sel_op2;
  logic [OPRN_WIDTH-1:0]   sel_oprn;
  logic                    sel_bad;

  assign any_req  = req0 | req1;
  assign sel      = (req0 & req1) ? ~last_q : req1;
  assign sel_op1  = sel ? op1_1  : op1_0;
  assign sel_op2  = sel ? op2_1  : op2_0;
  assign sel_oprn = sel ? oprn_1 : oprn_0;

`ifdef ALU_OPCHK_EN
  assign sel_bad = (sel_oprn < OPRN_WIDTH'(1)) || (sel_oprn > OPRN_WIDTH'(9));
`else
  assign sel_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      oprn_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      oprn_q  <= oprn_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    oprn_d  = oprn_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d = sel;
          if (sel_bad) begin
            // Rejected opcode: ALU inputs keep their previous values.
            res_d   = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            op1_d   = sel_op1;
            op2_d   = sel_op2;
            oprn_d  = sel_oprn;
            cnt_d   = CNT_INIT;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = alu_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ack0 = 1'b0;
    ack1 = 1'b0;
    busy = (state_q != ST_IDLE);
    if (state_q == ST_RESP) begin
      ack0 = ~gnt_q;
      ack1 = gnt_q;
    end
  end

  assign result_out = res_q;
  assign err_out    = err_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_oprn   = oprn_q;

endmodule
